// File: rtl/udp_rx_pkt_buffer.sv
// Receive-side payload buffer: bytes land in a circular RAM, each packet commits or rolls back
// on its end pulse, and committed lengths queue up for a byte-serial consumer.
module udp_rx_pkt_buffer #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LQ_W   = 2
) (
  input  logic        gmii_rx_clk,
  input  logic        reset_n,
  input  logic        payload_valid_i,
  input  logic [7:0]  payload_dat_i,
  input  logic        one_pkt_done_i,
  input  logic        pkt_error_i,
  output logic        data_overflow_o,
  output logic        pkt_avail_o,
  output logic [15:0] pkt_len_o,
  input  logic        rd_en_i,
  output logic        rd_valid_o,
  output logic        rd_last_o,
  output logic [7:0]  rd_dat_o,
  output logic [15:0] pkt_ok_cnt_o,
  output logic [15:0] pkt_drop_cnt_o
);
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LQC_W = LQ_W + 1;
  localparam int unsigned LQ_D  = 1 << LQ_W;

  typedef enum logic {RD_IDLE, RD_PKT} rd_state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [15:0]      r_lq  [LQ_D];
  logic [PTR_W-1:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  logic [LQ_W-1:0]  r_lq_wr, r_lq_rd;
  logic [LQC_W-1:0] r_lq_cnt;
  logic             r_ovf;
  logic [15:0]      r_ok_cnt, r_drop_cnt;
  rd_state_t        r_state;
  logic [15:0]      r_rd_left;
  logic             r_pkt_avail, r_rd_valid, r_rd_last;
  logic [15:0]      r_pkt_len;
  logic [7:0]       r_rd_dat;

  logic [PTR_W-1:0] w_used, w_len_ptr;
  logic [15:0]      w_len;
  logic             w_full, w_lq_full, w_wr_en, w_commit, w_rd_fire, w_pop;

  // Occupancy is measured against rd_ptr so unread bytes of the head packet stay protected.
  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_used == PTR_W'(DEPTH));
  assign w_len_ptr = r_wr_ptr - r_cmt_ptr;
  assign w_len     = 16'(w_len_ptr);
  assign w_lq_full = (r_lq_cnt == LQC_W'(LQ_D));
  assign w_wr_en   = payload_valid_i && !one_pkt_done_i && !w_full;
  assign w_commit  = one_pkt_done_i && !pkt_error_i && !r_ovf && !w_lq_full &&
                     (w_len_ptr != '0);
  assign w_rd_fire = (r_state == RD_PKT) && rd_en_i;
  assign w_pop     = w_rd_fire && (r_rd_left == 16'd1);

  // Storage arrays carry no reset.
  always_ff @(posedge gmii_rx_clk) begin
    if (w_wr_en)  r_mem[r_wr_ptr[ADDR_W-1:0]] <= payload_dat_i;
    if (w_commit) r_lq[r_lq_wr] <= w_len;
  end

  // Write side: pointer advance, overflow tracking, commit/rollback and counters.
  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_ovf      <= 1'b0;
      r_ok_cnt   <= '0;
      r_drop_cnt <= '0;
    end else if (one_pkt_done_i) begin
      r_ovf <= 1'b0;
      if (w_commit) begin
        r_cmt_ptr <= r_wr_ptr;
        if (r_ok_cnt != 16'hFFFF) r_ok_cnt <= r_ok_cnt + 16'd1;
      end else begin
        r_wr_ptr <= r_cmt_ptr;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (payload_valid_i) begin
      if (w_full) r_ovf    <= 1'b1;
      else        r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Length queue bookkeeping; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lq_wr  <= '0;
      r_lq_rd  <= '0;
      r_lq_cnt <= '0;
    end else begin
      if (w_commit) r_lq_wr <= r_lq_wr + 1'b1;
      if (w_pop)    r_lq_rd <= r_lq_rd + 1'b1;
      case ({w_commit, w_pop})
        2'b10:   r_lq_cnt <= r_lq_cnt + 1'b1;
        2'b01:   r_lq_cnt <= r_lq_cnt - 1'b1;
        default: r_lq_cnt <= r_lq_cnt;
      endcase
    end
  end

  // Read FSM: latch the head length, then stream bytes with one-cycle latency.
  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RD_IDLE;
      r_rd_ptr    <= '0;
      r_rd_left   <= '0;
      r_pkt_avail <= 1'b0;
      r_pkt_len   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_dat    <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (r_lq_cnt != '0) begin
            r_state     <= RD_PKT;
            r_rd_left   <= r_lq[r_lq_rd];
            r_pkt_len   <= r_lq[r_lq_rd];
            r_pkt_avail <= 1'b1;
          end
        end
        RD_PKT: begin
          if (w_rd_fire) begin
            r_rd_dat   <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_rd_left == 16'd1);
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_rd_left  <= r_rd_left - 16'd1;
            if (r_rd_left == 16'd1) begin
              r_state     <= RD_IDLE;
              r_pkt_avail <= 1'b0;
              r_pkt_len   <= '0;
            end
          end
        end
      endcase
    end
  end

  assign data_overflow_o = r_ovf;
  assign pkt_avail_o     = r_pkt_avail;
  assign pkt_len_o       = r_pkt_len;
  assign rd_valid_o      = r_rd_valid;
  assign rd_last_o       = r_rd_last;
  assign rd_dat_o        = r_rd_dat;
  assign pkt_ok_cnt_o    = r_ok_cnt;
  assign pkt_drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Bench for udp_rx_pkt_buffer: directed scenarios plus random traffic, scored against
// a byte-queue model of committed packets, the packet in flight and the consumer position.
module tb_udp_rx_pkt_buffer;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned LQ_W   = 2;
  localparam int DEPTH = 16;
  localparam int LQ_D  = 4;

  logic        gmii_rx_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        payload_valid_i = 1'b0;
  logic [7:0]  payload_dat_i = '0;
  logic        one_pkt_done_i = 1'b0;
  logic        pkt_error_i = 1'b0;
  logic        data_overflow_o;
  logic        pkt_avail_o;
  logic [15:0] pkt_len_o;
  logic        rd_en_i = 1'b0;
  logic        rd_valid_o;
  logic        rd_last_o;
  logic [7:0]  rd_dat_o;
  logic [15:0] pkt_ok_cnt_o;
  logic [15:0] pkt_drop_cnt_o;

  udp_rx_pkt_buffer #(.ADDR_W(ADDR_W), .LQ_W(LQ_W)) dut (
    .gmii_rx_clk    (gmii_rx_clk),
    .reset_n        (reset_n),
    .payload_valid_i(payload_valid_i),
    .payload_dat_i  (payload_dat_i),
    .one_pkt_done_i (one_pkt_done_i),
    .pkt_error_i    (pkt_error_i),
    .data_overflow_o(data_overflow_o),
    .pkt_avail_o    (pkt_avail_o),
    .pkt_len_o      (pkt_len_o),
    .rd_en_i        (rd_en_i),
    .rd_valid_o     (rd_valid_o),
    .rd_last_o      (rd_last_o),
    .rd_dat_o       (rd_dat_o),
    .pkt_ok_cnt_o   (pkt_ok_cnt_o),
    .pkt_drop_cnt_o (pkt_drop_cnt_o)
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  // Reference model: committed unread bytes, in-flight packet bytes, committed lengths.
  logic [7:0] m_data[$];
  logic [7:0] m_cur[$];
  int         m_len[$];
  int         m_rd_left, m_ok, m_drop, m_wait;
  bit         m_ovf, m_gap;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_data.delete(); m_cur.delete(); m_len.delete();
    m_rd_left = 0; m_ok = 0; m_drop = 0; m_wait = 0; m_ovf = 0; m_gap = 0;
  endtask

  // One clock: called at a negedge, updates the model from pre-edge state, checks after the edge.
  task automatic step(input bit rd, input bit wv, input logic [7:0] d, input bit dn, input bit er);
    bit         acc;
    bit         exp_last;
    logic [7:0] exp_d;
    acc = rd && (pkt_avail_o === 1'b1);
    exp_last = 1'b0;
    exp_d = '0;
    if (m_gap) chk("avail_gap", pkt_avail_o, 0);
    m_gap = 0;
    if (pkt_avail_o === 1'b1) begin
      chk("avail_has_pkt", m_len.size() != 0, 1);
      if (m_len.size() != 0) chk("pkt_len", pkt_len_o, m_len[0]);
      m_wait = 0;
    end else if (m_len.size() != 0) begin
      m_wait++;
      if (m_wait > 2) chk("avail_timeout", m_wait, 2);
    end else m_wait = 0;

    if (dn) begin
      if (!er && !m_ovf && m_len.size() < LQ_D && m_cur.size() != 0) begin
        foreach (m_cur[i]) m_data.push_back(m_cur[i]);
        m_len.push_back(m_cur.size());
        if (m_ok < 65535) m_ok++;
      end else if (m_drop < 65535) m_drop++;
      m_cur.delete();
      m_ovf = 0;
    end else if (wv) begin
      if (m_data.size() + m_cur.size() >= DEPTH) m_ovf = 1;
      else m_cur.push_back(d);
    end

    if (acc && m_len.size() != 0 && m_data.size() != 0) begin
      if (m_rd_left == 0) m_rd_left = m_len[0];
      exp_d = m_data.pop_front();
      exp_last = (m_rd_left == 1);
      m_rd_left--;
      if (exp_last) begin
        void'(m_len.pop_front());
        m_gap = 1;
      end
    end

    rd_en_i = rd; payload_valid_i = wv; payload_dat_i = d;
    one_pkt_done_i = dn; pkt_error_i = er;
    @(posedge gmii_rx_clk);
    #1;
    chk("rd_valid", rd_valid_o, acc);
    if (acc) begin
      chk("rd_dat", rd_dat_o, exp_d);
      chk("rd_last", rd_last_o, exp_last);
    end else chk("rd_last_idle", rd_last_o, 0);
    chk("overflow", data_overflow_o, m_ovf);
    chk("ok_cnt", pkt_ok_cnt_o, m_ok);
    chk("drop_cnt", pkt_drop_cnt_o, m_drop);
    @(negedge gmii_rx_clk);
  endtask

  task automatic do_reset();
    rd_en_i = 0; payload_valid_i = 0; payload_dat_i = '0; one_pkt_done_i = 0; pkt_error_i = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_overflow", data_overflow_o, 0);
    chk("rst_avail", pkt_avail_o, 0);
    chk("rst_len", pkt_len_o, 0);
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_last", rd_last_o, 0);
    chk("rst_dat", rd_dat_o, 0);
    chk("rst_ok", pkt_ok_cnt_o, 0);
    chk("rst_drop", pkt_drop_cnt_o, 0);
    model_clear();
    @(negedge gmii_rx_clk);
    @(negedge gmii_rx_clk);
    reset_n = 1'b1;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] base, input bit er);
    for (int i = 0; i < n; i++) step(0, 1, 8'(base + i), 0, 0);
    step(0, 0, 8'h00, 1, er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic wait_avail();
    for (int i = 0; i < 6 && pkt_avail_o !== 1'b1; i++) step(0, 0, 8'h00, 0, 0);
    chk("wait_avail", pkt_avail_o, 1);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (m_len.size() != 0 || pkt_avail_o === 1'b1); i++)
      step(1, 0, 8'h00, 0, 0);
    chk("drain_empty", m_len.size(), 0);
    chk("drain_avail", pkt_avail_o, 0);
  endtask

  initial begin
    bit rd, wv, dn, er;
    int r;
    model_clear();
    @(negedge gmii_rx_clk);
    do_reset();

    // Good 5-byte packet read back with last on the fifth byte.
    send_pkt(5, 8'h01, 0);
    wait_avail();
    chk("len_good5", pkt_len_o, 5);
    read_n(5);
    idle(2);

    // Errored packet drops; a following good packet reads back intact.
    send_pkt(10, 8'h20, 1);
    idle(2);
    chk("avail_after_err", pkt_avail_o, 0);
    send_pkt(3, 8'h40, 0);
    wait_avail();
    drain();

    // Overflow: 20 bytes into 16 with no reads.
    for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
    chk("ovf_set", data_overflow_o, 1);
    step(0, 0, 8'h00, 1, 0);
    chk("ovf_clear", data_overflow_o, 0);
    idle(3);
    chk("ovf_no_avail", pkt_avail_o, 0);

    // Queue full: fifth packet drops, sixth commits after one read.
    for (int k = 0; k < 5; k++) send_pkt(2, 8'(8'h70 + 2 * k), 0);
    wait_avail();
    chk("qfull_drop", pkt_drop_cnt_o, m_drop);
    read_n(2);
    send_pkt(2, 8'h90, 0);
    drain();

    // Concurrent write/read with commit on the final read cycle.
    send_pkt(10, 8'hA0, 0);
    wait_avail();
    for (int i = 0; i < 10; i++)
      step(1, (i >= 3 && i < 9), 8'(8'hB0 + i), (i == 9), 0);
    wait_avail();
    chk("len_after_gap", pkt_len_o, 6);
    drain();

    // Reset in the middle of a read.
    send_pkt(8, 8'hC0, 0);
    wait_avail();
    read_n(3);
    do_reset();
    send_pkt(4, 8'hD0, 0);
    wait_avail();
    drain();

    // Random traffic with alternating read-heavy and read-starved phases.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r  = $urandom_range(0, 99);
      rd = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      dn = (r < 7);
      wv = !dn && (r < 80);
      er = dn && ($urandom_range(0, 4) == 0);
      step(rd, wv, 8'($urandom_range(0, 255)), dn, er);
    end
    step(0, 0, 8'h00, 1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
